// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin arbiter that shares one ALU/datapath resource
// among (1 << IDX_WIDTH) requesters. A grant is held until the resource
// signals `done`. The grant is presented as a binary index and as a decoded
// one-hot (ACTIVE=1) or one-cold (ACTIVE=0) vector.
//
// Optional feature macro: ARBITER_TIMEOUT_EN
//   When defined, a busy counter forces a release after TIMEOUT busy cycles
//   without `done`, and the `timeout` port pulses for one cycle.
module alu_req_arbiter #(
    parameter int IDX_WIDTH = 2,
    parameter int ACTIVE    = 1,
    parameter int TIMEOUT   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [(1<<IDX_WIDTH)-1:0]   req,
    input  logic                        done,
    output logic [(1<<IDX_WIDTH)-1:0]   gnt,
    output logic [IDX_WIDTH-1:0]        gnt_idx,
    output logic                        gnt_valid
`ifdef ARBITER_TIMEOUT_EN
    ,
    output logic                        timeout
`endif
);

    localparam int   N   = 1 << IDX_WIDTH;
    localparam logic ACT = 1'(ACTIVE);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // A forced release only makes sense with at least two busy cycles.
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("alu_req_arbiter: TIMEOUT must be >= 2");
    end

    state_e               state_q, state_d;
    logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
    logic [IDX_WIDTH-1:0] gnt_idx_q, gnt_idx_d;
    logic                 gnt_valid_q, gnt_valid_d;

    logic                 win_found;
    logic [IDX_WIDTH-1:0] win_idx;
    logic [IDX_WIDTH-1:0] cand;
    logic                 force_rel;

`ifdef ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    // Busy counter: zero while idle (so it is clear on entry), counts busy cycles without done.
    always_comb begin
        force_rel = (state_q == BUSY) && !done && (cnt_q == CNT_W'(TIMEOUT - 1));
        cnt_d     = ((state_q == BUSY) && !done) ? cnt_q + CNT_W'(1) : '0;
        timeout_d = force_rel;
    end

    assign timeout = timeout_q;
`else
    assign force_rel = 1'b0;
`endif

    // Round-robin search: first set request starting at ptr, wrapping modulo N.
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = ptr_q + IDX_WIDTH'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state logic for the IDLE/BUSY machine and its registered outputs.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d     = BUSY;
                    gnt_idx_d   = win_idx;
                    gnt_valid_d = 1'b1;
                end
            end
            BUSY: begin
                // req is ignored here; only completion or a forced release ends the grant.
                if (done || force_rel) begin
                    state_d     = IDLE;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_idx_q + IDX_WIDTH'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    // State register; asynchronous reset drops any held grant immediately.
    // NOTE: non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
`ifdef ARBITER_TIMEOUT_EN
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
`ifdef ARBITER_TIMEOUT_EN
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    // Grant decode straight from the registers: no added latency, no glitches.
    always_comb begin
        gnt = {N{~ACT}};
        if (gnt_valid_q) begin
            gnt[gnt_idx_q] = ACT;
        end
    end

    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter. Directed scenarios plus a
// randomized run compared against an integer-level round-robin model.
// Build with ARBITER_TIMEOUT_EN defined to exercise the forced release.
module tb_alu_req_arbiter;

    localparam int IW  = 2;
    localparam int N   = 1 << IW;
    localparam int TMO = 4;
`ifdef ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req, req_n;
    logic          done, done_n;
    logic [N-1:0]  gnt, gnt_n;
    logic [IW-1:0] gnt_idx, gnt_idx_n;
    logic          gnt_valid, gnt_valid_n;
`ifdef ARBITER_TIMEOUT_EN
    logic          timeout, timeout_n;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state: plain integers.
    int m_ptr, m_idx, m_cnt;
    bit m_busy, m_to;

    always #5 clk = ~clk;

    alu_req_arbiter #(.IDX_WIDTH(IW), .ACTIVE(1), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid)
`ifdef ARBITER_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    alu_req_arbiter #(.IDX_WIDTH(IW), .ACTIVE(0), .TIMEOUT(TMO)) dut_n (
        .clk(clk), .rst(rst), .req(req_n), .done(done_n),
        .gnt(gnt_n), .gnt_idx(gnt_idx_n), .gnt_valid(gnt_valid_n)
`ifdef ARBITER_TIMEOUT_EN
        , .timeout(timeout_n)
`endif
    );

    function automatic void model_reset();
        m_ptr  = 0;
        m_idx  = 0;
        m_cnt  = 0;
        m_busy = 1'b0;
        m_to   = 1'b0;
    endfunction

    function automatic void model_release();
        m_busy = 1'b0;
        m_ptr  = (m_idx + 1) % N;
    endfunction

    function automatic void model_step(input logic [N-1:0] r, input logic d);
        bit found;
        m_to  = 1'b0;
        found = 1'b0;
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                if (!found && r[(m_ptr + k) % N]) begin
                    found  = 1'b1;
                    m_idx  = (m_ptr + k) % N;
                    m_busy = 1'b1;
                    m_cnt  = 0;
                end
            end
        end else if (d) begin
            model_release();
        end else if (TO_EN && m_cnt == TMO - 1) begin
            model_release();
            m_to = 1'b1;
        end else begin
            m_cnt++;
        end
    endfunction

    function automatic logic [N-1:0] exp_gnt(input bit act);
        logic [N-1:0] v;
        v = act ? '0 : '1;
        if (m_busy) v[m_idx] = act;
        return v;
    endfunction

    // Advance one clock; model follows the inputs sampled at the edge; outputs sampled #1 later.
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(req, done);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; done = 1'b0; req_n = '0; done_n = 1'b0;
        model_reset();
        tick(); tick();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp %b", gnt, 4'b0000); end
        checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", gnt_valid); end
        checks++; if (gnt_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", gnt_idx); end
        rst = 1'b0;
        tick();
        checks++; if (gnt_valid !== 1'b1 || gnt_idx !== 2'd0 || gnt !== 4'b0001) begin
            errors++; $display("FAIL reset_first_grant got v=%b idx=%0d gnt=%b exp v=1 idx=0 gnt=0001", gnt_valid, gnt_idx, gnt);
        end
        done = 1'b1;
        tick();
        checks++; if (gnt_valid !== 1'b0 || gnt !== 4'b0000) begin
            errors++; $display("FAIL reset_release got v=%b gnt=%b exp v=0 gnt=0000", gnt_valid, gnt);
        end
        done = 1'b0; req = '0;
        tick();
    endtask

    task automatic test_single();
        req = 4'b0100;
        tick();
        checks++; if (gnt !== 4'b0100 || gnt_idx !== 2'd2) begin
            errors++; $display("FAIL single_grant got idx=%0d gnt=%b exp idx=2 gnt=0100", gnt_idx, gnt);
        end
        req = '0; done = 1'b1;
        tick();
        checks++; if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_idx !== 2'd2) begin
            errors++; $display("FAIL single_release got v=%b idx=%0d gnt=%b exp v=0 idx=2 gnt=0000", gnt_valid, gnt_idx, gnt);
        end
        done = 1'b0; req = 4'b1111;
        tick();
        checks++; if (gnt_idx !== 2'd3 || gnt_valid !== 1'b1) begin
            errors++; $display("FAIL single_ptr_after got v=%b idx=%0d exp v=1 idx=3", gnt_valid, gnt_idx);
        end
        req = '0; done = 1'b1;
        tick();
        done = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        int seq [5] = '{0, 1, 2, 3, 0};
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            checks++; if (gnt_valid !== 1'b1 || gnt_idx !== IW'(seq[g]) || gnt !== N'(1 << seq[g])) begin
                errors++; $display("FAIL rr_grant%0d got v=%b idx=%0d gnt=%b exp idx=%0d", g, gnt_valid, gnt_idx, gnt, seq[g]);
            end
            tick();
            checks++; if (gnt_valid !== 1'b1 || gnt_idx !== IW'(seq[g])) begin
                errors++; $display("FAIL rr_hold%0d got v=%b idx=%0d exp v=1 idx=%0d", g, gnt_valid, gnt_idx, seq[g]);
            end
            done = 1'b1;
            tick();
            done = 1'b0;
            checks++; if (gnt_valid !== 1'b0) begin
                errors++; $display("FAIL rr_gap%0d got v=%b exp 0", g, gnt_valid);
            end
        end
    endtask

    task automatic test_wrap();
        req = 4'b1001;
        tick();
        checks++; if (gnt_idx !== 2'd3 || gnt !== 4'b1000) begin
            errors++; $display("FAIL wrap_grant3 got idx=%0d gnt=%b exp idx=3 gnt=1000", gnt_idx, gnt);
        end
        req = 4'b0001;
        tick();
        checks++; if (gnt_valid !== 1'b1 || gnt_idx !== 2'd3) begin
            errors++; $display("FAIL wrap_no_revoke got v=%b idx=%0d exp v=1 idx=3", gnt_valid, gnt_idx);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        checks++; if (gnt_idx !== 2'd0 || gnt !== 4'b0001) begin
            errors++; $display("FAIL wrap_grant0 got idx=%0d gnt=%b exp idx=0 gnt=0001", gnt_idx, gnt);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++; if (gnt_valid !== 1'b0 || gnt !== 4'b0000 || gnt_idx !== 2'd0) begin
            errors++; $display("FAIL wrap_async_rst got v=%b idx=%0d gnt=%b exp v=0 idx=0 gnt=0000", gnt_valid, gnt_idx, gnt);
        end
        tick();
        req = '0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_active_low();
        checks++; if (gnt_n !== 4'b1111 || gnt_valid_n !== 1'b0) begin
            errors++; $display("FAIL low_idle got v=%b gnt=%b exp v=0 gnt=1111", gnt_valid_n, gnt_n);
        end
        req_n = 4'b0010;
        tick();
        checks++; if (gnt_n !== 4'b1101 || gnt_idx_n !== 2'd1) begin
            errors++; $display("FAIL low_grant got idx=%0d gnt=%b exp idx=1 gnt=1101", gnt_idx_n, gnt_n);
        end
        req_n = '0; done_n = 1'b1;
        tick();
        done_n = 1'b0;
        checks++; if (gnt_n !== 4'b1111) begin
            errors++; $display("FAIL low_release got gnt=%b exp 1111", gnt_n);
        end
    endtask

`ifdef ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        req = 4'b0001;
        tick();
        req = '0;
        checks++; if (gnt_valid !== 1'b1 || gnt_idx !== 2'd0 || timeout !== 1'b0) begin
            errors++; $display("FAIL to_grant got v=%b idx=%0d to=%b exp v=1 idx=0 to=0", gnt_valid, gnt_idx, timeout);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (gnt_valid !== 1'b1 || timeout !== 1'b0) begin
                errors++; $display("FAIL to_hold%0d got v=%b to=%b exp v=1 to=0", i, gnt_valid, timeout);
            end
        end
        tick();
        checks++; if (gnt_valid !== 1'b0 || timeout !== 1'b1) begin
            errors++; $display("FAIL to_fire got v=%b to=%b exp v=0 to=1", gnt_valid, timeout);
        end
        tick();
        checks++; if (timeout !== 1'b0) begin
            errors++; $display("FAIL to_pulse_len got to=%b exp 0", timeout);
        end
        req = 4'b0001;
        tick();
        req = '0;
        checks++; if (gnt_valid !== 1'b1 || gnt_idx !== 2'd0) begin
            errors++; $display("FAIL to_regrant got v=%b idx=%0d exp v=1 idx=0", gnt_valid, gnt_idx);
        end
        tick(); tick(); tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++; $display("FAIL to_done_wins got v=%b to=%b exp v=0 to=0", gnt_valid, timeout);
        end
        tick();
        checks++; if (timeout !== 1'b0) begin
            errors++; $display("FAIL to_done_nopulse got to=%b exp 0", timeout);
        end
    endtask
`else
    task automatic test_no_timeout();
        req = 4'b0001;
        tick();
        req = '0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i % 25 == 24) begin
                checks++; if (gnt_valid !== 1'b1 || gnt_idx !== 2'd0) begin
                    errors++; $display("FAIL notimeout_hold%0d got v=%b idx=%0d exp v=1 idx=0", i, gnt_valid, gnt_idx);
                end
            end
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (gnt_valid !== 1'b0) begin
            errors++; $display("FAIL notimeout_release got v=%b exp 0", gnt_valid);
        end
    endtask
`endif

    task automatic test_random();
        logic [N-1:0] eg;
        for (int c = 0; c < 400; c++) begin
            req  = N'($urandom_range(0, (1 << N) - 1));
            done = ($urandom_range(0, 2) == 0);
            tick();
            eg = exp_gnt(1'b1);
            checks++; if (gnt_valid !== m_busy || gnt_idx !== IW'(m_idx) || gnt !== eg) begin
                errors++; $display("FAIL rand_c%0d got v=%b idx=%0d gnt=%b exp v=%b idx=%0d gnt=%b",
                                   c, gnt_valid, gnt_idx, gnt, m_busy, m_idx, eg);
            end
`ifdef ARBITER_TIMEOUT_EN
            checks++; if (timeout !== m_to) begin
                errors++; $display("FAIL rand_to_c%0d got %b exp %b", c, timeout, m_to);
            end
`endif
        end
        req = '0; done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_active_low();
`ifdef ARBITER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Round-robin arbiter that shares one ALU/datapath resource among `1 << IDX_WIDTH` requesters. It holds a grant for each operation until the resource signals completion. The grant is presented two ways: as a binary index and as a one-hot/one-cold decoded vector using the same polarity convention as the team's decoder. It sits between the requesting units and the shared resource's operand mux and select logic.

## Interface
- `IDX_WIDTH`, 2: requester index width; N = `1 << IDX_WIDTH` requesters.
- `ACTIVE`, 1: polarity of `gnt`. 1 means the granted line is high; 0 means it is low.
- `TIMEOUT`, 16: maximum number of busy cycles before a forced release. Used only when `ARBITER_TIMEOUT_EN` is defined. Must be ≥ 2.

Ports:
- `clk` input 1: single clock; rising edge.
- `rst` input 1: asynchronous reset, active-high.
- `req` input N: request vector; bit k is requester k.
- `done` input 1: the resource has completed the granted operation. Sampled only in BUSY.
- `gnt` output N: decoded grant.
  - Bit k is `ACTIVE[0]` iff `gnt_valid` is high and `gnt_idx` = k.
  - All other bits are `~ACTIVE[0]`.
- `gnt_idx` output IDX_WIDTH: index of the current grant; drives the resource operand select.
- `gnt_valid` output 1: high while a grant is held (state BUSY).
- `timeout` output 1: one-cycle pulse on a forced release. Present only with `ARBITER_TIMEOUT_EN`.

## Operation
- State machine, two states: IDLE and BUSY.
- Internal round-robin pointer `ptr` (IDX_WIDTH bits) holds the highest-priority index.
- **IDLE**
  - If `req` ≠ 0, select the first set bit searching `ptr`, `ptr+1`, … wrapping modulo N.
  - At the next edge: `gnt_idx` ← winner, `gnt_valid` ← 1, state ← BUSY.
  - If `req` = 0, remain in IDLE.
  - `done` is ignored.
- **BUSY**
  - `gnt_idx` and `gnt` are held constant.
  - `req` changes are ignored; the grant is not revoked if the requester drops `req`.
  - On `done` = 1 at an edge: `gnt_valid` ← 0, `ptr` ← `gnt_idx + 1` (wraps from N-1 to 0), state ← IDLE.
- After a release, `gnt_idx` retains its last value; only `gnt_valid` and `gnt` change.
- Decode of `gnt` is combinational from the `gnt_valid`/`gnt_idx` registers, so it carries no extra latency and is glitch-free relative to the registers.
- Reset values:
  - state IDLE
  - `ptr` 0
  - `gnt_idx` 0
  - `gnt_valid` 0
  - `gnt` all `~ACTIVE[0]`
  - `timeout` 0
  - busy counter 0
- Reset mid-operation drops the grant immediately (asynchronously), with no completion required.

## Timing
- Request-to-grant latency is 1 cycle: `req` sampled at edge n means the grant is visible after edge n.
- `done` sampled at edge m means the grant is deasserted after edge m.
- A new grant may appear after edge m+1. The minimum gap between consecutive grants is one cycle with `gnt_valid` = 0.
- `done` asserted in the same cycle the grant first becomes visible is accepted. This gives a minimum BUSY length of 1 cycle.
- Simultaneous requests resolve by `ptr` order only. No requester waits more than N-1 grants.

## Configuration
- Macro: `ARBITER_TIMEOUT_EN`.
- **Defined**
  - The `timeout` port exists.
  - A busy counter of width `$clog2(TIMEOUT)` clears on entry to BUSY and increments each BUSY cycle without `done`.
  - When the counter equals `TIMEOUT-1` and `done` = 0, the next edge performs a release identical to `done` (including the `ptr` update), and `timeout` pulses high for exactly that one following cycle.
  - If `done` and the timeout condition coincide, the release counts as normal completion and `timeout` stays 0.
- **Undefined**
  - No counter and no `timeout` port.
  - BUSY persists until `done` or `rst`.

## Test plan
1. **Reset with requests pending:** `rst`=1 with `req`=4'b1111.
   - During reset: `gnt`=4'b0000, `gnt_valid`=0, `gnt_idx`=0.
   - After `rst` deasserts: grant to 0 one edge later.
2. **Single requester:** `req`=4'b0100 only.
   - Next edge: `gnt`=4'b0100, `gnt_idx`=2.
   - `done` pulse: `gnt`=4'b0000 after that edge.
   - Then `ptr`=3.
3. **Round-robin fairness:** `req`=4'b1111 held, `done` asserted one cycle into each grant.
   - Grant order is 0,1,2,3,0.
   - Each grant is separated by one idle cycle.
4. **Wrap and priority:** after a grant to 0 completes (`ptr`=1), apply `req`=4'b1001.
   - Grant goes to 3, then to 0.
   - Dropping `req[3]` mid-BUSY does not revoke the grant.
   - `rst` mid-BUSY clears `gnt` asynchronously.
5. **Active-low polarity:** `ACTIVE`=0.
   - Idle: `gnt`=4'b1111.
   - Grant to requester 1: `gnt`=4'b1101.
6. **Timeout:** with `ARBITER_TIMEOUT_EN`, `TIMEOUT`=4, grant held without `done`.
   - Released after 4 BUSY cycles; `timeout` high for 1 cycle.
   - With `done` on cycle 4: no timeout pulse.
   - Without the macro: grant still held after 100 cycles.
